// File: rtl/wb_block.sv
// Write-back stage: MEM/WB pipeline register, write-back data select, regfile write port,
// NZP condition codes, bypass copy and retired-instruction counter.
module wb_block #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                in_valid,
    input  logic                in_load_regfile,
    input  logic                in_load_cc,
    input  logic [1:0]          in_wb_sel,
    input  logic                in_byte_hi,
    input  logic [2:0]          in_dest,
    input  logic [15:0]         in_alu,
    input  logic [15:0]         in_mem,
    input  logic [15:0]         in_pc,
    output logic                reg_load,
    output logic [2:0]          reg_dest,
    output logic [15:0]         reg_data,
    output logic [2:0]          cc,
    output logic                fwd_valid,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_count
);

    // MEM/WB register fields
    logic                valid_q;
    logic                load_regfile_q;
    logic                load_cc_q;
    logic [1:0]          wb_sel_q;
    logic                byte_hi_q;
    logic [2:0]          dest_q;
    logic [15:0]         alu_q;
    logic [15:0]         mem_q;
    logic [15:0]         pc_q;
    // Set once a held (stalled) instruction has committed, so it commits only once.
    logic                done_q;
    logic [2:0]          cc_q;
    logic [RETIRE_W-1:0] retire_count_q;

    logic [7:0]  byte_sel;
    logic [15:0] data_sel;
    logic [2:0]  cc_next;
    logic        commit;

    // Write-back value select, including sign-extended byte loads.
    always_comb begin
        byte_sel = byte_hi_q ? mem_q[15:8] : mem_q[7:0];
        data_sel = alu_q;
        case (wb_sel_q)
            2'b00:   data_sel = alu_q;
            2'b01:   data_sel = mem_q;
            2'b10:   data_sel = {{8{byte_sel[7]}}, byte_sel};
            default: data_sel = pc_q;
        endcase
    end

    // NZP derived from the value being written back; exactly one bit set.
    always_comb begin
        if (data_sel[15]) begin
            cc_next = 3'b100;
        end else if (data_sel == 16'h0000) begin
            cc_next = 3'b010;
        end else begin
            cc_next = 3'b001;
        end
    end

    // Outputs and bypass are a direct view of the WB register.
    always_comb begin
        commit       = valid_q & ~done_q;
        reg_load     = commit & load_regfile_q;
        reg_dest     = dest_q;
        reg_data     = data_sel;
        fwd_valid    = reg_load;
        retire       = commit;
        cc           = cc_q;
        retire_count = retire_count_q;
    end

    // Pipeline register, write-once tracking, condition codes and retire counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q        <= 1'b0;
            load_regfile_q <= 1'b0;
            load_cc_q      <= 1'b0;
            wb_sel_q       <= 2'b00;
            byte_hi_q      <= 1'b0;
            dest_q         <= 3'd0;
            alu_q          <= 16'h0000;
            mem_q          <= 16'h0000;
            pc_q           <= 16'h0000;
            done_q         <= 1'b0;
            cc_q           <= 3'b010;
            retire_count_q <= '0;
        end else begin
            if (commit) begin
                retire_count_q <= retire_count_q + 1'b1;
                if (load_cc_q) begin
                    cc_q <= cc_next;
                end
            end
            if (!stall) begin
                valid_q        <= in_valid;
                load_regfile_q <= in_load_regfile;
                load_cc_q      <= in_load_cc;
                wb_sel_q       <= in_wb_sel;
                byte_hi_q      <= in_byte_hi;
                dest_q         <= in_dest;
                alu_q          <= in_alu;
                mem_q          <= in_mem;
                pc_q           <= in_pc;
                done_q         <= 1'b0;
            end else if (commit) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_block.sv
// Self-checking bench for wb_block: per-cycle comparison against a behavioural model,
// plus hand-computed literal expectations at key points.
module tb_wb_block;

    localparam int unsigned RETIRE_W = 16;

    logic                clk = 1'b0;
    logic                reset_n, stall, in_valid, in_load_regfile, in_load_cc, in_byte_hi;
    logic [1:0]          in_wb_sel;
    logic [2:0]          in_dest;
    logic [15:0]         in_alu, in_mem, in_pc;
    logic                reg_load, fwd_valid, retire;
    logic [2:0]          reg_dest, cc;
    logic [15:0]         reg_data;
    logic [RETIRE_W-1:0] retire_count;

    int checks = 0;
    int errors = 0;

    wb_block #(.RETIRE_W(RETIRE_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .in_valid        (in_valid),
        .in_load_regfile (in_load_regfile),
        .in_load_cc      (in_load_cc),
        .in_wb_sel       (in_wb_sel),
        .in_byte_hi      (in_byte_hi),
        .in_dest         (in_dest),
        .in_alu          (in_alu),
        .in_mem          (in_mem),
        .in_pc           (in_pc),
        .reg_load        (reg_load),
        .reg_dest        (reg_dest),
        .reg_data        (reg_data),
        .cc              (cc),
        .fwd_valid       (fwd_valid),
        .retire          (retire),
        .retire_count    (retire_count)
    );

    always #5 clk = ~clk;

    // Model: the instruction currently sitting in write-back, and whether it already committed.
    logic        m_valid, m_rf, m_lcc, m_hi, m_committed;
    logic [1:0]  m_sel;
    logic [2:0]  m_dest, m_cc;
    logic [15:0] m_alu, m_mem, m_pc;
    int          m_count;

    function automatic logic [15:0] model_data();
        int v;
        case (m_sel)
            2'd0: v = int'(m_alu);
            2'd1: v = int'(m_mem);
            2'd2: begin
                v = m_hi ? int'(m_mem) / 256 : int'(m_mem) % 256;
                if (v >= 128) v = v - 256;
            end
            default: v = int'(m_pc);
        endcase
        return 16'(v);
    endfunction

    function automatic logic [2:0] nzp(input logic [15:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output to the model, then advance model and DUT by one clock.
    task automatic step();
        logic live;
        live = m_valid && !m_committed;
        check("reg_load", 32'(reg_load), 32'(live && m_rf));
        check("fwd_valid", 32'(fwd_valid), 32'(live && m_rf));
        check("retire", 32'(retire), 32'(live));
        check("reg_dest", 32'(reg_dest), 32'(m_dest));
        check("reg_data", 32'(reg_data), 32'(model_data()));
        check("cc", 32'(cc), 32'(m_cc));
        check("retire_count", 32'(retire_count), 32'(m_count));
        if (!reset_n) begin
            {m_valid, m_rf, m_lcc, m_hi, m_committed, m_sel, m_dest} = '0;
            {m_alu, m_mem, m_pc} = '0;
            m_cc = 3'b010;
            m_count = 0;
        end else begin
            if (live) begin
                if (m_lcc) m_cc = nzp(model_data());
                m_count = (m_count + 1) % (1 << RETIRE_W);
            end
            if (!stall) begin
                m_valid = in_valid; m_rf = in_load_regfile; m_lcc = in_load_cc;
                m_sel = in_wb_sel; m_hi = in_byte_hi; m_dest = in_dest;
                m_alu = in_alu; m_mem = in_mem; m_pc = in_pc;
                m_committed = 1'b0;
            end else if (live) begin
                m_committed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic rf, input logic lcc, input logic [1:0] sel,
                             input logic hi, input logic [2:0] dest, input logic [15:0] alu,
                             input logic [15:0] mem, input logic [15:0] pc);
        in_valid = 1'b1; in_load_regfile = rf; in_load_cc = lcc; in_wb_sel = sel;
        in_byte_hi = hi; in_dest = dest; in_alu = alu; in_mem = mem; in_pc = pc;
    endtask

    task automatic bubble();
        in_valid = 1'b0; in_load_regfile = 1'b1; in_load_cc = 1'b1;
    endtask

    initial begin
        int n_load, n_ret;
        logic [15:0] saved_count;
        {m_valid, m_rf, m_lcc, m_hi, m_committed, m_sel, m_dest} = '0;
        {m_alu, m_mem, m_pc} = '0;
        m_cc = 3'b010; m_count = 0;
        reset_n = 1'b0; stall = 1'b0;
        set_instr(1'b1, 1'b1, 2'd0, 1'b0, 3'd1, 16'h1234, 16'h0, 16'h0);
        @(posedge clk); #1;
        step(); step();
        check("lit_reset_load", 32'(reg_load), 32'd0);
        check("lit_reset_cc", 32'(cc), 32'h2);
        check("lit_reset_count", 32'(retire_count), 32'd0);
        reset_n = 1'b1;

        // ADD r3 <- 0x8001
        set_instr(1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 16'h8001, 16'h0, 16'h0);
        step(); bubble();
        check("lit_add_load", 32'(reg_load), 32'd1);
        check("lit_add_dest", 32'(reg_dest), 32'd3);
        check("lit_add_data", 32'(reg_data), 32'h8001);
        step();
        check("lit_add_cc", 32'(cc), 32'h4);
        check("lit_add_count", 32'(retire_count), 32'd1);

        // LDB low byte, LDB high byte, LDR zero
        set_instr(1'b1, 1'b1, 2'd2, 1'b0, 3'd4, 16'h0, 16'h7F80, 16'h0);
        step(); bubble();
        check("lit_ldb_lo_data", 32'(reg_data), 32'hFF80);
        step();
        check("lit_ldb_lo_cc", 32'(cc), 32'h4);
        set_instr(1'b1, 1'b1, 2'd2, 1'b1, 3'd4, 16'h0, 16'h7F80, 16'h0);
        step(); bubble();
        check("lit_ldb_hi_data", 32'(reg_data), 32'h007F);
        step();
        check("lit_ldb_hi_cc", 32'(cc), 32'h1);
        set_instr(1'b1, 1'b1, 2'd1, 1'b0, 3'd5, 16'hFFFF, 16'h0000, 16'h0);
        step(); bubble();
        check("lit_ldr_data", 32'(reg_data), 32'h0000);
        step();
        check("lit_ldr_cc", 32'(cc), 32'h2);

        // JSR link: no cc update
        set_instr(1'b1, 1'b0, 2'd3, 1'b0, 3'd7, 16'h8000, 16'h0, 16'h3002);
        step(); bubble();
        check("lit_jsr_data", 32'(reg_data), 32'h3002);
        check("lit_jsr_dest", 32'(reg_dest), 32'd7);
        step();
        check("lit_jsr_cc", 32'(cc), 32'h2);

        // Stall hold: one write, one retire
        saved_count = retire_count;
        set_instr(1'b1, 1'b1, 2'd0, 1'b0, 3'd2, 16'h0005, 16'h0, 16'h0);
        step();
        n_load = 0; n_ret = 0;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 1'b1, 2'(i), 1'b1, 3'(i), 16'h8000, 16'h8000, 16'h8000);
            n_load += int'(reg_load); n_ret += int'(retire);
            step();
        end
        stall = 1'b0; bubble();
        n_load += int'(reg_load); n_ret += int'(retire);
        check("lit_stall_loads", 32'(n_load), 32'd1);
        check("lit_stall_retires", 32'(n_ret), 32'd1);
        check("lit_stall_count", 32'(retire_count), 32'(saved_count + 16'd1));
        check("lit_stall_cc", 32'(cc), 32'h1);
        step();

        // Bubbles never retire
        saved_count = retire_count;
        for (int i = 0; i < 5; i++) begin
            check("lit_bubble_load", 32'(reg_load), 32'd0);
            step();
        end
        check("lit_bubble_count", 32'(retire_count), 32'(saved_count));

        // Counter wrap
        reset_n = 1'b0; step(); reset_n = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            set_instr(1'(i % 2), 1'b1, 2'd0, 1'b0, 3'(i), 16'h8000 | 16'(i), 16'h0, 16'h0);
            step();
        end
        bubble(); step();
        check("lit_count_ffff", 32'(retire_count), 32'hFFFF);
        check("lit_wrap_cc", 32'(cc), 32'h4);
        set_instr(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
        step(); bubble(); step();
        check("lit_count_wrap", 32'(retire_count), 32'h0000);

        // Reset while a stalled, uncommitted instruction is held
        set_instr(1'b1, 1'b1, 2'd0, 1'b0, 3'd6, 16'h0001, 16'h0, 16'h0);
        step();
        stall = 1'b1; reset_n = 1'b0;
        step();
        check("lit_rst_load", 32'(reg_load), 32'd0);
        check("lit_rst_cc", 32'(cc), 32'h2);
        check("lit_rst_count", 32'(retire_count), 32'd0);
        reset_n = 1'b1;
        step();
        check("lit_rel_load", 32'(reg_load), 32'd0);
        check("lit_rel_count", 32'(retire_count), 32'd0);
        stall = 1'b0; bubble();
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_block.md
Name: wb_block

Overview:
- Write-back stage of the lc3b pipeline; the writing end of the register-file interface that the decode stage reads.
- Holds the MEM/WB pipeline register and selects the write-back value (ALU result, load word, sign-extended load byte, or link PC).
- Drives the regfile write port (reg_load/reg_dest/reg_data) and the NZP condition-code register.
- Exports a bypass copy for the hazard unit and a retired-instruction counter.

Parameters:
RETIRE_W, 16, width of retire counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset
stall  in  1  hold WB pipeline register (upstream frozen)
in_valid  in  1  MEM stage holds a real instruction (0 = bubble)
in_load_regfile  in  1  instruction writes a GPR
in_load_cc  in  1  instruction updates NZP
in_wb_sel  in  2  00 alu, 01 mem word, 10 mem byte, 11 pc
in_byte_hi  in  1  address bit 0 for byte loads
in_dest  in  3  destination register
in_alu  in  16  ALU result
in_mem  in  16  memory read word
in_pc  in  16  link address (PC+2) for JSR/JSRR/TRAP
reg_load  out  1  regfile write enable
reg_dest  out  3  regfile write address
reg_data  out  16  regfile write data
cc  out  3  NZP, {n,z,p}
fwd_valid  out  1  reg_data is a valid pending GPR write
retire  out  1  one-cycle pulse per retired instruction
retire_count  out  RETIRE_W  retired-instruction count

Behaviour:
- Reset (reset_n=0 at edge): WB register valid=0, all stored fields 0, done=0, cc=3'b010, retire_count=0. Consequently reg_load=0, fwd_valid=0, retire=0, reg_dest=0, reg_data=0. Reset wins over stall and in_valid.
- Capture: at each edge with stall=0, the WB register loads all in_* fields, valid<=in_valid, done<=0. With stall=1, the register holds its contents.
- Data select (combinational from the WB register):
  - 00: alu.
  - 01: mem.
  - 10: mem byte, sign-extended to 16; in_byte_hi=1 selects mem[15:8], 0 selects mem[7:0].
  - 11: pc.
  - reg_data=selected value; reg_dest=stored dest.
- Write-once rule:
  - reg_load = valid & load_regfile & ~done.
  - At any edge where valid & ~done and stall=1: done<=1, so a held instruction writes the regfile and updates cc exactly once.
  - done clears on capture.
- Latency: inputs captured at edge N drive reg_* during cycle N+1; regfile and cc commit at edge N+1. The decode stage sees the new value from cycle N+2 unless bypassed.
- CC: at an edge where valid & load_cc & ~done, cc is set from reg_data:
  - 100 if bit15=1.
  - 010 if reg_data==0.
  - 001 otherwise.
  - Exactly one bit is set at all times.
  - load_cc is independent of load_regfile.
- Bypass: fwd_valid = reg_load; its dest and data are reg_dest and reg_data.
- Retire:
  - retire = valid & ~done.
  - retire_count increments at that edge and wraps from all-ones to 0.
  - Bubbles (valid=0) never retire, write, or touch cc.
- Reset mid-stall clears done and valid; a held instruction is discarded without writing.

Test Plan:
- ADD: in_valid=1, load_regfile=1, load_cc=1, wb_sel=00, dest=3, alu=0x8001, stall=0 -> next cycle reg_load=1, reg_dest=3, reg_data=0x8001; after the following edge cc=100 and retire_count=1.
- LDB: wb_sel=10, mem=0x7F80; byte_hi=0 -> reg_data=0xFF80, cc=100; byte_hi=1 -> reg_data=0x007F, cc=001. LDR with mem=0 -> reg_data=0x0000, cc=010.
- JSR link: wb_sel=11, pc=0x3002, dest=7, load_cc=0 -> reg_data=0x3002, reg_dest=7, cc unchanged from its prior value.
- Stall hold: capture an ADD, then stall=1 for 3 cycles -> reg_load high for exactly 1 cycle, retire pulses once, retire_count +1 only.
- Bubble and wrap: in_valid=0 for 5 cycles -> reg_load=0 and count unchanged. Preset the count to 0xFFFF via 65535 retires, retire one more -> retire_count=0x0000.
- Reset: assert reset_n=0 while a stalled, unretired instruction is held -> next cycle reg_load=0, cc=010, retire_count=0, and no write occurs after release.
